// File: rtl/warp_imem.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses from a
// 64-bit word array that is loaded through a side write port.
module warp_imem #(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 1,
   parameter logic [38:0] BASE_ADDR = 39'h4000000000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ren,
   input  logic [38:0] i_raddr,
   output logic        o_valid,
   output logic [63:0] o_rdata,
   output logic        o_err,
   input  logic        i_wen,
   input  logic [38:0] i_waddr,
   input  logic [63:0] i_wdata
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [38:0] SPAN = 39'(DEPTH * 8);

   logic [63:0] r_mem   [DEPTH];
   logic        r_valid [LATENCY];
   logic        r_err   [LATENCY];
   logic [63:0] r_data  [LATENCY];

   logic [38:0]   w_roff;
   logic [38:0]   w_woff;
   logic          w_rok;
   logic          w_wok;
   logic [AW-1:0] w_ridx;
   logic [AW-1:0] w_widx;

   // Offsets wrap in 39 bits, so addresses below the base also land out of range.
   assign w_roff = i_raddr - BASE_ADDR;
   assign w_woff = i_waddr - BASE_ADDR;
   assign w_rok  = (w_roff < SPAN) && (i_raddr[2:0] == 3'b000);
   assign w_wok  = (w_woff < SPAN) && (i_waddr[2:0] == 3'b000);
   assign w_ridx = w_roff[AW+2:3];
   assign w_widx = w_woff[AW+2:3];

   always_ff @(posedge i_clk) begin
      if (i_wen && w_wok) begin
         r_mem[w_widx] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_valid[i] <= 1'b0;
            r_err[i]   <= 1'b0;
         end
      end else begin
         r_valid[0] <= i_ren;
         r_err[0]   <= i_ren && !w_rok;
         for (int i = 1; i < LATENCY; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_err[i]   <= r_err[i-1];
         end
      end
   end

   // Stage 0 reads before the same-edge write lands, giving read-first behaviour.
   always_ff @(posedge i_clk) begin
      r_data[0] <= (i_ren && w_rok) ? r_mem[w_ridx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
         r_data[i] <= r_data[i-1];
      end
   end

   // Data regs are not reset; gating by the final valid bit keeps outputs clean.
   assign o_valid = r_valid[LATENCY-1];
   assign o_err   = r_valid[LATENCY-1] & r_err[LATENCY-1];
   assign o_rdata = r_valid[LATENCY-1] ? r_data[LATENCY-1] : '0;

endmodule

// File: tb/tb_warp_imem.sv
// Self-checking bench for warp_imem: three instances (LATENCY 1,2,3) share all
// inputs and are compared each cycle against a request-history reference model.
module tb_warp_imem;

   localparam int          DEPTH = 1024;
   localparam logic [38:0] BASE  = 39'h4000000000;
   localparam int          MAXC  = 8192;

   logic        clk   = 1'b0;
   logic        rstN  = 1'b0;
   logic        ren   = 1'b0;
   logic        wen   = 1'b0;
   logic [38:0] raddr = '0;
   logic [38:0] waddr = '0;
   logic [63:0] wdata = '0;

   logic        oValid [3];
   logic        oErr   [3];
   logic [63:0] oRdata [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gDut
      warp_imem #(.DEPTH(DEPTH), .LATENCY(g + 1), .BASE_ADDR(BASE)) u_dut (
         .i_clk   (clk),
         .i_rst_n (rstN),
         .i_ren   (ren),
         .i_raddr (raddr),
         .o_valid (oValid[g]),
         .o_rdata (oRdata[g]),
         .o_err   (oErr[g]),
         .i_wen   (wen),
         .i_waddr (waddr),
         .i_wdata (wdata)
      );
   end

   // Reference model: memory image plus the response each sampling edge produced.
   logic [63:0] refMem [DEPTH];
   bit          hv [MAXC];
   bit          he [MAXC];
   logic [63:0] hd [MAXC];
   int          cyc = 0;
   int          resetBoundary = 0;
   int          compared = 0;
   int          mismatched = 0;

   function automatic bit addrOk(logic [38:0] a);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      return (la >= lb) && (la < lb + DEPTH * 8) && (la % 8 == 0);
   endfunction

   function automatic int addrIdx(logic [38:0] a);
      return int'((longint'(a) - longint'(BASE)) / 8);
   endfunction

   // Expected {valid, err, data} for the instance of the given latency now.
   function automatic logic [65:0] expOut(int lat);
      int s = cyc - lat + 1;
      if (s <= resetBoundary || !hv[s]) return '0;
      return {1'b1, he[s], hd[s]};
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      hv[cyc] = 1'b0;
      he[cyc] = 1'b0;
      hd[cyc] = '0;
      if (rstN && ren) begin
         hv[cyc] = 1'b1;
         if (addrOk(raddr)) hd[cyc] = refMem[addrIdx(raddr)];
         else               he[cyc] = 1'b1;
      end
      if (wen && addrOk(waddr)) refMem[addrIdx(waddr)] = wdata;
      #1;
   endtask

   task automatic loadMem();
      wen = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         waddr = BASE + 39'(8 * i);
         wdata = {$urandom, $urandom};
         step();
      end
      wen = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      for (int l = 0; l < 3; l++) begin
         compared++;
         if ({oValid[l], oErr[l], oRdata[l]} !== 66'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_init lat%0d: got v=%0b e=%0b d=%h, want all zero", l + 1, oValid[l], oErr[l], oRdata[l]);
         end
      end
      ren = 1'b1;
      raddr = BASE;
      for (int n = 0; n < 3; n++) begin
         step();
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL reset_hold lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
      ren = 1'b0;
      #2 rstN = 1'b1;
   endtask

   task automatic test_single_read();
      wen = 1'b1; waddr = BASE; wdata = 64'h08206113_07800093;
      step();
      wen = 1'b0; ren = 1'b1; raddr = BASE;
      step();
      ren = 1'b0;
      compared++;
      if (oValid[0] !== 1'b1 || oErr[0] !== 1'b0 || oRdata[0] !== 64'h08206113_07800093) begin
         mismatched++;
         $display("[TB] FAIL single_read: got v=%0b e=%0b d=%h, want v=1 e=0 d=0820611307800093", oValid[0], oErr[0], oRdata[0]);
      end
      step();
      compared++;
      if (oValid[0] !== 1'b0 || oRdata[0] !== 64'd0) begin
         mismatched++;
         $display("[TB] FAIL single_read_drop: got v=%0b d=%h, want v=0 d=0", oValid[0], oRdata[0]);
      end
      for (int n = 0; n < 3; n++) begin
         step();
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL single_tail lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waddr = BASE + 39'(8 * i);
         wdata = 64'(i);
         step();
      end
      wen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ren = (i < 4);
         raddr = BASE + 39'(8 * i);
         step();
         compared++;
         if (oValid[2] !== (i >= 2 && i <= 5) || oRdata[2] !== ((i >= 2 && i <= 5) ? 64'(i - 2) : 64'd0)) begin
            mismatched++;
            $display("[TB] FAIL b2b_lat3 step%0d: got v=%0b d=%h", i, oValid[2], oRdata[2]);
         end
         for (int l = 1; l <= 2; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL b2b lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
   endtask

   task automatic test_errors();
      logic [38:0] bad [3];
      bad[0] = 39'h3FFFFFFFF8;
      bad[1] = 39'h4000002000;
      bad[2] = 39'h4000000004;
      for (int b = 0; b < 3; b++) begin
         ren = 1'b1; raddr = bad[b];
         step();
         ren = 1'b0;
         compared++;
         if (oValid[0] !== 1'b1 || oErr[0] !== 1'b1 || oRdata[0] !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL err_resp addr=%h: got v=%0b e=%0b d=%h, want v=1 e=1 d=0", bad[b], oValid[0], oErr[0], oRdata[0]);
         end
         for (int n = 0; n < 3; n++) begin
            step();
            for (int l = 1; l <= 3; l++) begin
               compared++;
               if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
                  mismatched++;
                  $display("[TB] FAIL err_pipe lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
               end
            end
         end
      end
   endtask

   task automatic test_collision();
      wen = 1'b1; waddr = BASE + 39'd40; wdata = 64'hAAAA;
      step();
      wdata = 64'hBBBB; ren = 1'b1; raddr = BASE + 39'd40;
      step();
      wen = 1'b0;
      compared++;
      if (oRdata[0] !== 64'hAAAA) begin
         mismatched++;
         $display("[TB] FAIL collision_old: got d=%h, want 000000000000aaaa", oRdata[0]);
      end
      step();
      ren = 1'b0;
      compared++;
      if (oRdata[0] !== 64'hBBBB) begin
         mismatched++;
         $display("[TB] FAIL collision_new: got d=%h, want 000000000000bbbb", oRdata[0]);
      end
      for (int n = 0; n < 3; n++) begin
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL collision_pipe lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
         step();
      end
   endtask

   task automatic test_reset_midflight();
      ren = 1'b1; raddr = BASE + 39'd8;
      step();
      ren = 1'b0;
      step();
      #2 rstN = 1'b0;
      resetBoundary = cyc;
      #1;
      for (int l = 0; l < 3; l++) begin
         compared++;
         if ({oValid[l], oErr[l], oRdata[l]} !== 66'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_async lat%0d: got v=%0b e=%0b d=%h, want all zero", l + 1, oValid[l], oErr[l], oRdata[l]);
         end
      end
      ren = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL reset_window lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
      #2 rstN = 1'b1;
      raddr = BASE + 39'd16;
      for (int n = 0; n < 5; n++) begin
         ren = (n == 0);
         step();
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL reset_after lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
   endtask

   task automatic test_idle_gaps();
      bit pat [6] = '{1, 0, 1, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         ren = pat[i];
         raddr = BASE + 39'(8 * (i + 1));
         step();
         compared++;
         if (oValid[1] !== (i >= 1 && pat[i-1]) || (!oValid[1] && oRdata[1] !== 64'd0)) begin
            mismatched++;
            $display("[TB] FAIL idle_gap_lat2 step%0d: got v=%0b d=%h", i, oValid[1], oRdata[1]);
         end
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL idle_gap lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int idx = $urandom_range(0, DEPTH - 1);
         ren = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0:       raddr = BASE - 39'(8 * $urandom_range(1, 4));
            1:       raddr = BASE + 39'(DEPTH * 8) + 39'(8 * $urandom_range(0, 100));
            2:       raddr = BASE + 39'(8 * idx) + 39'($urandom_range(1, 7));
            default: raddr = BASE + 39'(8 * idx);
         endcase
         wen = ($urandom_range(0, 2) == 0);
         waddr = ($urandom_range(0, 4) == 0) ? BASE + 39'(8 * idx) + 39'($urandom_range(0, 7))
                                             : BASE + 39'(8 * $urandom_range(0, DEPTH - 1));
         wdata = {$urandom, $urandom};
         step();
         for (int l = 1; l <= 3; l++) begin
            compared++;
            if ({oValid[l-1], oErr[l-1], oRdata[l-1]} !== expOut(l)) begin
               mismatched++;
               $display("[TB] FAIL random lat%0d cyc%0d: got v=%0b e=%0b d=%h, want %h", l, cyc, oValid[l-1], oErr[l-1], oRdata[l-1], expOut(l));
            end
         end
      end
      ren = 1'b0;
      wen = 1'b0;
   endtask

   initial begin
      test_reset();
      loadMem();
      test_single_read();
      test_back_to_back();
      test_errors();
      test_collision();
      test_reset_midflight();
      test_idle_gaps();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
